// File: rtl/game_sequencer_pkg.sv
// Shared types and defaults for the Frogger game-flow sequencer.
package game_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_HIT       = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam int DEF_NUM_LIVES       = 4;
    localparam int DEF_NUM_BITS        = 4;
    localparam int DEF_RESPAWN_CYCLES  = 25_000_000;
    localparam int DEF_GAMEOVER_CYCLES = 75_000_000;

    // One shared timer covers both freezes, so it is sized for the longer one.
    function automatic int timer_width(input int respawn_cycles, input int gameover_cycles);
        int longest;
        longest = (respawn_cycles > gameover_cycles) ? respawn_cycles : gameover_cycles;
        return $clog2(longest);
    endfunction

endpackage

// File: rtl/game_timer.sv
// Loadable down-counter; holds at zero until reloaded.
module game_timer #(
    parameter int WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Value,
    output logic             o_Zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            count <= '0;
        end else if (i_Load) begin
            count <= i_Value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign o_Zero = (count == '0);

endmodule

// File: rtl/game_sequencer.sv
// Frogger game-flow controller: game states, lives counter and car-direction reload.
//
//  state        | meaning
//  -------------+--------------------------------------------------------------
//  ST_IDLE      | waiting for a fresh start press (switches released, then pressed)
//  ST_RUNNING   | frog under player control; collisions and level-ups act here
//  ST_HIT       | respawn freeze after a non-fatal hit; collisions ignored
//  ST_GAME_OVER | last life lost; hold, then back to IDLE with lives at zero
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int NUM_LIVES       = DEF_NUM_LIVES,
    parameter int NUM_BITS        = DEF_NUM_BITS,
    parameter int RESPAWN_CYCLES  = DEF_RESPAWN_CYCLES,
    parameter int GAMEOVER_CYCLES = DEF_GAMEOVER_CYCLES
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    input  logic                 i_Start,
    input  logic                 i_Collision,
    input  logic                 i_Level_Up,
    input  logic [NUM_BITS-1:0]  i_LFSR_Data,
    output logic                 o_Game_Active,
    output logic                 o_Freeze,
    output logic                 o_Frog_Respawn,
    output logic [NUM_LIVES-1:0] o_Lives,
    output logic [NUM_BITS-1:0]  o_Reverse,
    output logic                 o_Reverse_Load,
    output logic [1:0]           o_State
);

    localparam int TIMER_WIDTH = timer_width(RESPAWN_CYCLES, GAMEOVER_CYCLES);

    state_t                 state, state_next;
    logic [NUM_LIVES-1:0]   lives, lives_next;
    logic                   respawn_next;
    logic                   reload_req;
    logic                   reload_pending;
    logic                   armed;
    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_value;
    logic                   timer_zero;

    game_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_timer (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Load  (timer_load),
        .i_Value (timer_value),
        .o_Zero  (timer_zero)
    );

    always_comb begin
        state_next   = state;
        lives_next   = lives;
        timer_load   = 1'b0;
        timer_value  = '0;
        respawn_next = 1'b0;
        // A zero pattern would freeze the car directions, so it is always replaced.
        reload_req   = (o_Reverse == '0);
        case (state)
            ST_IDLE: begin
                if (i_Start && armed) begin
                    state_next   = ST_RUNNING;
                    lives_next   = '1;
                    respawn_next = 1'b1;
                    reload_req   = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (i_Collision) begin
                    lives_next = lives >> 1;
                    timer_load = 1'b1;
                    if (lives == NUM_LIVES'(1)) begin
                        state_next  = ST_GAME_OVER;
                        timer_value = TIMER_WIDTH'(GAMEOVER_CYCLES - 1);
                    end else begin
                        state_next   = ST_HIT;
                        timer_value  = TIMER_WIDTH'(RESPAWN_CYCLES - 1);
                        respawn_next = 1'b1;
                    end
                end else if (i_Level_Up) begin
                    reload_req = 1'b1;
                end
            end
            ST_HIT: begin
                if (timer_zero) state_next = ST_RUNNING;
            end
            ST_GAME_OVER: begin
                if (timer_zero) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state          <= ST_IDLE;
            lives          <= '1;
            o_Reverse      <= '0;
            o_Reverse_Load <= 1'b0;
            o_Frog_Respawn <= 1'b0;
            o_Game_Active  <= 1'b0;
            o_Freeze       <= 1'b0;
            armed          <= 1'b0;
            reload_pending <= 1'b0;
        end else begin
            state          <= state_next;
            lives          <= lives_next;
            o_Frog_Respawn <= respawn_next;
            o_Game_Active  <= (state_next == ST_RUNNING);
            o_Freeze       <= (state_next == ST_HIT) || (state_next == ST_GAME_OVER);
            // Start must be released before it counts again.
            armed          <= !i_Start;
            if ((reload_pending || reload_req) && (i_LFSR_Data != '0)) begin
                o_Reverse      <= i_LFSR_Data;
                o_Reverse_Load <= 1'b1;
                reload_pending <= 1'b0;
            end else begin
                o_Reverse_Load <= 1'b0;
                reload_pending <= reload_pending || reload_req;
            end
        end
    end

    assign o_Lives = lives;
    assign o_State = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with a cycle-level behavioural game model.
module tb_game_sequencer;

    localparam int NL  = 4;
    localparam int NB  = 4;
    localparam int RC  = 8;
    localparam int GOC = 16;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HIT  = 2;
    localparam int M_GO   = 3;

    logic          i_Clk = 1'b0;
    logic          i_Reset = 1'b1;
    logic          i_Start = 1'b0;
    logic          i_Collision = 1'b0;
    logic          i_Level_Up = 1'b0;
    logic [NB-1:0] i_LFSR_Data = '0;
    logic          o_Game_Active;
    logic          o_Freeze;
    logic          o_Frog_Respawn;
    logic [NL-1:0] o_Lives;
    logic [NB-1:0] o_Reverse;
    logic          o_Reverse_Load;
    logic [1:0]    o_State;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    int          m_mode = M_IDLE;
    int          m_lives_n = NL;
    int          m_left = 0;
    bit          m_armed = 0;
    bit          m_pending = 0;
    logic [NB-1:0] m_rev = '0;
    bit          m_load = 0;
    bit          m_respawn = 0;

    game_sequencer #(
        .NUM_LIVES       (NL),
        .NUM_BITS        (NB),
        .RESPAWN_CYCLES  (RC),
        .GAMEOVER_CYCLES (GOC)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_Start        (i_Start),
        .i_Collision    (i_Collision),
        .i_Level_Up     (i_Level_Up),
        .i_LFSR_Data    (i_LFSR_Data),
        .o_Game_Active  (o_Game_Active),
        .o_Freeze       (o_Freeze),
        .o_Frog_Respawn (o_Frog_Respawn),
        .o_Lives        (o_Lives),
        .o_Reverse      (o_Reverse),
        .o_Reverse_Load (o_Reverse_Load),
        .o_State        (o_State)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [NL-1:0] therm(input int n);
        return NL'((1 << n) - 1);
    endfunction

    task automatic model_update(input bit rst, input bit st, input bit col, input bit lu,
                                input logic [NB-1:0] lfsr);
        bit req;
        if (rst) begin
            m_mode = M_IDLE; m_lives_n = NL; m_left = 0; m_armed = 0;
            m_pending = 0; m_rev = '0; m_load = 0; m_respawn = 0;
        end else begin
            req = (m_rev == '0);
            m_respawn = 0;
            m_load = 0;
            if (m_mode == M_IDLE) begin
                if (st && m_armed) begin
                    m_mode = M_RUN; m_lives_n = NL; m_respawn = 1; req = 1;
                end
            end else if (m_mode == M_RUN) begin
                if (col) begin
                    m_lives_n = m_lives_n - 1;
                    if (m_lives_n == 0) begin
                        m_mode = M_GO; m_left = GOC;
                    end else begin
                        m_mode = M_HIT; m_left = RC; m_respawn = 1;
                    end
                end else if (lu) begin
                    req = 1;
                end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) m_mode = (m_mode == M_HIT) ? M_RUN : M_IDLE;
            end
            if ((m_pending || req) && lfsr != '0) begin
                m_rev = lfsr; m_load = 1; m_pending = 0;
            end else begin
                m_pending = m_pending || req;
            end
            m_armed = !st;
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit col, input bit lu,
                        input logic [NB-1:0] lfsr);
        i_Reset = rst; i_Start = st; i_Collision = col; i_Level_Up = lu; i_LFSR_Data = lfsr;
        @(posedge i_Clk);
        model_update(rst, st, col, lu, lfsr);
        @(negedge i_Clk);
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 4'h0);
        step(1, 1, 0, 0, 4'h0);
        checks++;
        if (o_State !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_State); end
        checks++;
        if (o_Lives !== 4'b1111) begin errors++; $display("FAIL reset_lives: got %b expected 1111", o_Lives); end
        checks++;
        if (o_Reverse !== 4'h0) begin errors++; $display("FAIL reset_reverse: got %h expected 0", o_Reverse); end
        checks++;
        if ({o_Game_Active, o_Freeze, o_Frog_Respawn, o_Reverse_Load} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {o_Game_Active, o_Freeze, o_Frog_Respawn, o_Reverse_Load});
        end
    endtask

    task automatic test_start_arming();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 4'h0);
            checks++;
            if (o_State !== 2'd0) begin errors++; $display("FAIL held_start_idle: got %0d expected 0", o_State); end
        end
        step(0, 0, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'h3);
        checks++;
        if (o_Game_Active !== 1'b1) begin errors++; $display("FAIL start_active: got %b expected 1", o_Game_Active); end
        checks++;
        if (o_Lives !== 4'b1111) begin errors++; $display("FAIL start_lives: got %b expected 1111", o_Lives); end
        checks++;
        if (o_Frog_Respawn !== 1'b1) begin errors++; $display("FAIL start_respawn: got %b expected 1", o_Frog_Respawn); end
        step(0, 1, 0, 0, 4'h3);
        checks++;
        if (o_Frog_Respawn !== 1'b0) begin errors++; $display("FAIL start_respawn_pulse: got %b expected 0", o_Frog_Respawn); end
    endtask

    task automatic test_hit();
        int n;
        step(0, 0, 1, 0, 4'h0);
        checks++;
        if (o_Lives !== 4'b0111) begin errors++; $display("FAIL hit_lives: got %b expected 0111", o_Lives); end
        checks++;
        if (o_State !== 2'd2 || o_Frog_Respawn !== 1'b1) begin
            errors++; $display("FAIL hit_entry: got state %0d respawn %b expected 2 1", o_State, o_Frog_Respawn);
        end
        n = (o_Freeze === 1'b1) ? 1 : 0;
        for (int g = 0; g < 40; g++) begin
            step(0, 0, 1, 0, 4'h0);
            if (o_Freeze !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != RC) begin errors++; $display("FAIL hit_length: got %0d expected %0d", n, RC); end
        checks++;
        if (o_State !== 2'd1 || o_Lives !== 4'b0111) begin
            errors++; $display("FAIL hit_exit: got state %0d lives %b expected 1 0111", o_State, o_Lives);
        end
    endtask

    task automatic test_game_over();
        logic [NL-1:0] exp_lives;
        int n;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0, 4'h0);
            exp_lives = therm(2 - k);
            checks++;
            if (o_Lives !== exp_lives) begin errors++; $display("FAIL go_lives%0d: got %b expected %b", k, o_Lives, exp_lives); end
            if (k < 2) begin
                for (int g = 0; g < 40; g++) begin
                    step(0, 0, 0, 0, 4'h0);
                    if (o_State === 2'd1) break;
                end
                checks++;
                if (o_State !== 2'd1) begin errors++; $display("FAIL go_rerun%0d: got %0d expected 1", k, o_State); end
            end
        end
        checks++;
        if (o_State !== 2'd3 || o_Freeze !== 1'b1) begin
            errors++; $display("FAIL go_entry: got state %0d freeze %b expected 3 1", o_State, o_Freeze);
        end
        n = 1;
        for (int g = 0; g < 60; g++) begin
            step(0, 1, 1, 1, 4'h0);
            if (o_State !== 2'd3) break;
            n++;
        end
        checks++;
        if (n != GOC) begin errors++; $display("FAIL go_length: got %0d expected %0d", n, GOC); end
        checks++;
        if (o_State !== 2'd0 || o_Lives !== 4'b0000) begin
            errors++; $display("FAIL go_idle: got state %0d lives %b expected 0 0000", o_State, o_Lives);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 4'h0);
            checks++;
            if (o_State !== 2'd0) begin errors++; $display("FAIL go_no_restart: got %0d expected 0", o_State); end
        end
    endtask

    task automatic test_reverse();
        step(0, 0, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'h3);
        step(0, 0, 0, 1, 4'hA);
        checks++;
        if (o_Reverse !== 4'hA || o_Reverse_Load !== 1'b1) begin
            errors++; $display("FAIL rev_load: got %h load %b expected a 1", o_Reverse, o_Reverse_Load);
        end
        step(0, 0, 0, 1, 4'h0);
        step(0, 0, 0, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);
        checks++;
        if (o_Reverse !== 4'hA || o_Reverse_Load !== 1'b0) begin
            errors++; $display("FAIL rev_wait: got %h load %b expected a 0", o_Reverse, o_Reverse_Load);
        end
        step(0, 0, 0, 0, 4'h5);
        checks++;
        if (o_Reverse !== 4'h5 || o_Reverse_Load !== 1'b1) begin
            errors++; $display("FAIL rev_late: got %h load %b expected 5 1", o_Reverse, o_Reverse_Load);
        end
        step(0, 0, 0, 0, 4'h9);
        checks++;
        if (o_Reverse !== 4'h5 || o_Reverse_Load !== 1'b0) begin
            errors++; $display("FAIL rev_once: got %h load %b expected 5 0", o_Reverse, o_Reverse_Load);
        end
    endtask

    task automatic test_collision_levelup();
        step(0, 0, 1, 1, 4'hC);
        checks++;
        if (o_Lives !== 4'b0111 || o_State !== 2'd2) begin
            errors++; $display("FAIL both_hit: got lives %b state %0d expected 0111 2", o_Lives, o_State);
        end
        checks++;
        if (o_Reverse_Load !== 1'b0 || o_Reverse !== 4'h5) begin
            errors++; $display("FAIL both_noload: got %h load %b expected 5 0", o_Reverse, o_Reverse_Load);
        end
        step(0, 0, 0, 1, 4'h9);
        checks++;
        if (o_Reverse_Load !== 1'b0 || o_Reverse !== 4'h5) begin
            errors++; $display("FAIL hit_levelup: got %h load %b expected 5 0", o_Reverse, o_Reverse_Load);
        end
    endtask

    task automatic test_reset_mid_hit();
        step(0, 0, 0, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);
        step(1, 0, 0, 0, 4'h0);
        checks++;
        if (o_State !== 2'd0 || o_Lives !== 4'b1111 || o_Freeze !== 1'b0 || o_Reverse !== 4'h0) begin
            errors++;
            $display("FAIL midreset: got state %0d lives %b freeze %b rev %h expected 0 1111 0 0",
                     o_State, o_Lives, o_Freeze, o_Reverse);
        end
        step(0, 0, 0, 0, 4'h0);
        checks++;
        if (o_Reverse_Load !== 1'b0 || o_Reverse !== 4'h0) begin
            errors++; $display("FAIL midreset_wait: got %h load %b expected 0 0", o_Reverse, o_Reverse_Load);
        end
        step(0, 0, 0, 0, 4'h6);
        checks++;
        if (o_Reverse_Load !== 1'b1 || o_Reverse !== 4'h6) begin
            errors++; $display("FAIL midreset_reload: got %h load %b expected 6 1", o_Reverse, o_Reverse_Load);
        end
    endtask

    task automatic test_random();
        bit rst, st, col, lu;
        logic [NB-1:0] lfsr;
        for (int c = 0; c < 4000; c++) begin
            rst  = ($urandom_range(0, 299) == 0);
            st   = ($urandom_range(0, 3) == 0);
            col  = ($urandom_range(0, 11) == 0);
            lu   = ($urandom_range(0, 7) == 0);
            lfsr = ($urandom_range(0, 2) == 0) ? '0 : NB'($urandom);
            step(rst, st, col, lu, lfsr);
            checks++;
            if (o_State !== 2'(m_mode)) begin errors++; $display("FAIL rand_state c%0d: got %0d expected %0d", c, o_State, m_mode); end
            checks++;
            if (o_Lives !== therm(m_lives_n)) begin errors++; $display("FAIL rand_lives c%0d: got %b expected %b", c, o_Lives, therm(m_lives_n)); end
            checks++;
            if (o_Reverse !== m_rev || o_Reverse_Load !== m_load) begin
                errors++; $display("FAIL rand_reverse c%0d: got %h/%b expected %h/%b", c, o_Reverse, o_Reverse_Load, m_rev, m_load);
            end
            checks++;
            if (o_Frog_Respawn !== m_respawn) begin errors++; $display("FAIL rand_respawn c%0d: got %b expected %b", c, o_Frog_Respawn, m_respawn); end
            checks++;
            if (o_Game_Active !== (m_mode == M_RUN) || o_Freeze !== (m_mode == M_HIT || m_mode == M_GO)) begin
                errors++; $display("FAIL rand_flags c%0d: got active %b freeze %b for mode %0d", c, o_Game_Active, o_Freeze, m_mode);
            end
        end
    endtask

    initial begin
        @(negedge i_Clk);
        test_reset();
        test_start_arming();
        test_hit();
        test_game_over();
        test_reverse();
        test_collision_levelup();
        test_reset_mid_hit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
